fetch_unit: RTL and testbench

//  Program-counter and fetch stage. Drives PC into the 9-bit instruction ROM, registers the returned
//  9-bit instruction into an instruction register (IR) for decode/execute, and redirects PC on taken BNE.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and halt detection for the fetch stage.
// Optional FETCH_PERF_CNT_EN adds cycle_count / squash_count performance counters.
`default_nettype none

module fetch_unit #(
  parameter int              PC_W      = 9,
  parameter int              INST_W    = 9,
  parameter logic [PC_W-1:0]   START_PC  = '0,
  parameter logic [INST_W-1:0] HALT_INST = 9'h1FF
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   PC,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       cycle_count,
  output logic [7:0]        squash_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          // A taken branch squashes the fetch at the current PC, halt word included.
          if (branch_taken && valid_q) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else if (inst_in == HALT_INST) begin
            state_d = S_HALT;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            ir_d    = inst_in;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PC         = pc_q;
  assign inst_out   = ir_q;
  assign inst_valid = valid_q;
  assign done       = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;
  logic [7:0]  sq_q, sq_d;
  logic        w_squash;

  assign w_squash = (state_q == S_RUN) && !stall && branch_taken && valid_q;

  always_comb begin
    cyc_d = cyc_q;
    sq_d  = sq_q;
    if (state_q != S_RUN) begin
      if (start) begin
        cyc_d = '0;
        sq_d  = '0;
      end
    end else begin
      if (cyc_q != '1) cyc_d = cyc_q + 16'd1;
      if (w_squash && (sq_q != '1)) sq_d = sq_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      sq_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      sq_q  <= sq_d;
    end
  end

  assign cycle_count  = cyc_q;
  assign squash_count = sq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a spec-level fetch model compared every cycle.
`default_nettype none

module tb_fetch_unit;

  logic       CLK;
  logic       reset_n;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [8:0] branch_target;
  logic [8:0] PC;
  logic [8:0] inst_in;
  logic [8:0] inst_out;
  logic       inst_valid;
  logic       done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_count;
  logic [7:0]  squash_count;
`endif

  logic [8:0] rom [512];
  assign inst_in = rom[PC];

  fetch_unit dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .PC           (PC),
    .inst_in      (inst_in),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid),
    .done         (done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cycle_count  (cycle_count),
    .squash_count (squash_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: running flag, PC as an integer address, IR word and flags.
  bit         m_run   = 0;
  int         m_pc    = 0;
  logic [8:0] m_ir    = '0;
  bit         m_valid = 0;
  bit         m_done  = 0;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 0; m_pc <= 0; m_ir <= '0; m_valid <= 0; m_done <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_pc <= 0; m_valid <= 0; m_done <= 0;
      end
    end else if (!stall) begin
      if (branch_taken && m_valid) begin
        m_pc <= int'(branch_target); m_valid <= 0;
      end else if (rom[m_pc] == 9'h1FF) begin
        m_run <= 0; m_done <= 1; m_valid <= 0;
      end else begin
        m_ir <= rom[m_pc]; m_valid <= 1; m_pc <= (m_pc + 1) % 512;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmp_pc", int'(PC), m_pc);
      chk("cmp_ir", int'(inst_out), int'(m_ir));
      chk("cmp_valid", int'(inst_valid), int'(m_valid));
      chk("cmp_done", int'(done), int'(m_done));
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic fill_rom(input int last);
    for (int i = 0; i < 512; i++)
      rom[i] = (i <= last) ? 9'($urandom % 511) : 9'h1FF;
  endtask

  task automatic wait_pc(input int a);
    int n = 0;
    while (m_pc != a && n < 1000) begin tick(); n++; end
    if (m_pc != a) chk("wait_pc_timeout", m_pc, a);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    if (!done) chk("wait_done_timeout", int'(done), 1);
  endtask

  task automatic run_b();
    start = 1; tick(); start = 0;
    chk("b_start_pc", int'(PC), 0);
    chk("b_start_done", int'(done), 0);
    wait_pc(20);
    stall = 1;
    repeat (3) begin
      tick();
      chk("stall_pc", int'(PC), 20);
      chk("stall_ir", int'(inst_out), int'(9'h123));
    end
    stall = 0; tick();
    chk("stall_resume_pc", int'(PC), 21);
    wait_pc(37);
    branch_taken = 1; branch_target = 9'd39; tick();
    chk("br_pc", int'(PC), 39);
    chk("br_bubble", int'(inst_valid), 0);
    branch_target = 9'd100; tick(); branch_taken = 0;
    chk("br_ignored_pc", int'(PC), 40);
    chk("br_ir", int'(inst_out), int'(rom[39]));
    wait_pc(45);
    branch_taken = 1; branch_target = 9'd59; tick(); branch_taken = 0;
    chk("nohalt_pc", int'(PC), 59);
    chk("nohalt_done", int'(done), 0);
    wait_pc(100);
    start = 1; tick(); start = 0;
    chk("run_start_ignored", int'(PC), 101);
    wait_done();
    chk("end_pc", int'(PC), 257);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1; start = 0; stall = 0; branch_taken = 0; branch_target = '0;
    fill_rom(3);
    rom[0] = 9'h0C5; rom[1] = 9'h041; rom[2] = 9'h042; rom[3] = 9'h043;
    #1 reset_n = 0;
    tick(); tick();
    chk("rst_pc", int'(PC), 0);
    chk("rst_ir", int'(inst_out), 0);
    chk("rst_valid", int'(inst_valid), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1;
    chk_en = 1;

    // Short program: four instructions then the halt word.
    start = 1; tick(); start = 0;
    chk("a_c1_pc", int'(PC), 0);
    chk("a_c1_valid", int'(inst_valid), 0);
    tick();
    chk("a_c2_ir", int'(inst_out), int'(9'h0C5));
    chk("a_c2_valid", int'(inst_valid), 1);
    tick(); tick(); tick();
    chk("a_c5_ir", int'(inst_out), int'(9'h043));
    chk("a_c5_pc", int'(PC), 4);
    tick();
    chk("a_c6_done", int'(done), 1);
    chk("a_c6_pc", int'(PC), 4);
    chk("a_c6_valid", int'(inst_valid), 0);
    repeat (3) tick();
    chk("a_halt_hold", int'(done), 1);

    // Long program ending at 257, with stall, branches and a cancelled halt; run twice.
    fill_rom(256);
    rom[19] = 9'h123;
    rom[45] = 9'h1FF;
    run_b();
    repeat (2) tick();
    run_b();

    // Start under stall from HALT, then PC wrap 511 -> 0.
    fill_rom(511);
    rom[8] = 9'h1FF;
    stall = 1; start = 1; tick(); start = 0; stall = 0;
    chk("c_start_pc", int'(PC), 0);
    chk("c_start_done", int'(done), 0);
    wait_pc(6);
    branch_taken = 1; branch_target = 9'd510; tick(); branch_taken = 0;
    chk("c_br_pc", int'(PC), 510);
    tick();
    chk("c_pc_511", int'(PC), 511);
    tick();
    chk("c_wrap_pc", int'(PC), 0);
    chk("c_wrap_ir", int'(inst_out), int'(rom[511]));
    wait_done();
    chk("c_end_pc", int'(PC), 8);

    // Asynchronous reset mid-run.
    fill_rom(256);
    start = 1; tick(); start = 0;
    wait_pc(37);
    #2 reset_n = 0;
    #1;
    chk("d_rst_pc", int'(PC), 0);
    chk("d_rst_valid", int'(inst_valid), 0);
    chk("d_rst_done", int'(done), 0);
    tick();
    reset_n = 1;
    repeat (5) tick();
    chk("d_idle_pc", int'(PC), 0);
    chk("d_idle_valid", int'(inst_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
